// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiplier back end: field widths, the
// exponent saturation value, the packer FSM states and the exception flags.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } fp_state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

endpackage

// File: rtl/fp_sticky_shifter.sv
// Serial right shifter for the subnormal path. It shifts one bit per cycle
// and keeps the last bit shifted out (guard) and the OR of every earlier
// shifted-out bit (sticky), so rounding and inexact need no wide shifter.
module fp_sticky_shifter #(
    parameter int MANT_W  = 24,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MANT_W-1:0]  load_mant,
    input  logic [SHIFT_W-1:0] load_cnt,
    output logic               busy,
    output logic               done,
    output logic [MANT_W-1:0]  mant_q,
    output logic               guard,
    output logic               sticky
);

    logic [SHIFT_W-1:0] cnt_q;

    // Load a new operand, or shift once per cycle while the counter is nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mant_q <= '0;
            cnt_q  <= '0;
            guard  <= 1'b0;
            sticky <= 1'b0;
        end else if (load) begin
            mant_q <= load_mant;
            cnt_q  <= load_cnt;
            guard  <= 1'b0;
            sticky <= 1'b0;
        end else if (busy) begin
            sticky <= sticky | guard;
            guard  <= mant_q[0];
            mant_q <= mant_q >> 1;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    // done marks the cycle whose closing edge performs the final shift.
    always_comb begin
        busy = (cnt_q != '0);
        done = (cnt_q == SHIFT_W'(1));
    end

endmodule

// File: rtl/fp_result_packer.sv
// Back-end stage of the FP multiplier: subnormal shift, optional rounding,
// IEEE-754 single packing and exception flags.
// Optional feature macro: FP_PACK_RNE_EN (round-to-nearest-even on the
// subnormal path; truncation when undefined).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in OUT and
// result/flags stay frozen until out_ready completes the transfer.
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int MANT_W  = 24,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign,
    input  logic [7:0]         Ez,
    input  logic [MANT_W-1:0]  mant,
    input  logic               underflow_flag,
    input  logic               overflow_case,
    input  logic [SHIFT_W-1:0] mantissaReqiredModify,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        result,
    output logic               overflow,
    output logic               underflow,
    output logic               inexact,
    output fp_state_t          dbg_state
);

    fp_state_t state_q, state_d;

    logic      accept;
    logic      is_ovf;
    logic      sh_load;
    logic      sh_busy, sh_done;
    logic      sh_guard, sh_sticky;
    logic [MANT_W-1:0] sh_mant;

    logic [31:0] res_q;
    fp_flags_t   flags_q;
    logic        sign_q;
    logic        uf_q;

    logic                     rnd;
    logic [EXP_W+FRAC_W-1:0]  pack_sum;
    fp_flags_t                flags_out;

    // Accept decode; overflow outranks the underflow request.
    always_comb begin
        accept  = in_valid && in_ready;
        is_ovf  = overflow_case || (Ez == EXP_MAX);
        sh_load = accept && underflow_flag && !is_ovf;
    end

    fp_sticky_shifter #(
        .MANT_W  (MANT_W),
        .SHIFT_W (SHIFT_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_mant (mant),
        .load_cnt  (mantissaReqiredModify),
        .busy      (sh_busy),
        .done      (sh_done),
        .mant_q    (sh_mant),
        .guard     (sh_guard),
        .sticky    (sh_sticky)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a zero shift amount skips SHIFT entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sh_load && (mantissaReqiredModify != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_done || !sh_busy) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the non-subnormal results at acceptance; the subnormal result is
    // built from the shifter, which holds still once shifting ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
            sign_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else if (accept) begin
            sign_q <= sign;
            uf_q   <= underflow_flag && !is_ovf;
            if (is_ovf) begin
                res_q   <= {sign, EXP_MAX, {FRAC_W{1'b0}}};
                flags_q <= '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
            end else if (underflow_flag) begin
                res_q   <= '0;
                flags_q <= '0;
            end else if (!mant[MANT_W-1]) begin
                res_q   <= {sign, {(EXP_W+FRAC_W){1'b0}}};
                flags_q <= '0;
            end else begin
                res_q   <= {sign, Ez, mant[MANT_W-2:0]};
                flags_q <= '0;
            end
        end
    end

    // Subnormal pack: the hidden bit lands in the exponent LSB, so a set bit 23
    // or a rounding carry out of the fraction naturally yields exponent 1.
    always_comb begin
`ifdef FP_PACK_RNE_EN
        rnd = sh_guard & (sh_sticky | sh_mant[0]);
`else
        rnd = 1'b0;
`endif
        pack_sum = (EXP_W+FRAC_W)'(sh_mant) + (EXP_W+FRAC_W)'(rnd);
    end

    // Output selection between the captured result and the subnormal pack.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
        dbg_state = state_q;
        if (uf_q) begin
            result    = {sign_q, pack_sum};
            flags_out = '{overflow: 1'b0, underflow: 1'b1,
                          inexact: sh_guard | sh_sticky};
        end else begin
            result    = res_q;
            flags_out = flags_q;
        end
        overflow  = flags_out.overflow;
        underflow = flags_out.underflow;
        inexact   = flags_out.inexact;
    end

endmodule

// File: tb/tb_fp_result_packer.sv
// Self-checking bench for fp_result_packer: directed test-plan vectors,
// stall, reset mid-shift, back-to-back and randomized operations against a
// behavioural model.
module tb_fp_result_packer;

`ifdef FP_PACK_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  Ez;
    logic [23:0] mant;
    logic        underflow_flag;
    logic        overflow_case;
    logic [4:0]  mantissaReqiredModify;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    fp_pkg::fp_state_t dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [34:0] exp_q[$];

    fp_result_packer dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .sign                  (sign),
        .Ez                    (Ez),
        .mant                  (mant),
        .underflow_flag        (underflow_flag),
        .overflow_case         (overflow_case),
        .mantissaReqiredModify (mantissaReqiredModify),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .result                (result),
        .overflow              (overflow),
        .underflow             (underflow),
        .inexact               (inexact),
        .dbg_state             (dbg_state)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {result[31:0], overflow, underflow, inexact} from the rules.
    function automatic logic [34:0] model(input logic s, input logic [7:0] ez,
                                          input logic [23:0] m, input logic uf,
                                          input logic ovc, input logic [4:0] n);
        longint unsigned full, kept, low, sum;
        logic g, st, rnd;
        int nn;
        nn = int'(n);
        if (ovc || ez == 8'hFF) return {s, 8'hFF, 23'h0, 3'b101};
        if (uf) begin
            full = longint'(m);
            kept = full >> nn;
            g    = (nn == 0) ? 1'b0 : (((full >> (nn - 1)) & 64'd1) != 0);
            low  = (nn <= 1) ? 64'd0 : (full & ((64'd1 << (nn - 1)) - 64'd1));
            st   = (low != 0);
            rnd  = RNE ? (g & (st | kept[0])) : 1'b0;
            sum  = kept + longint'(rnd);
            return {s, sum[30:0], 1'b0, 1'b1, g | st};
        end
        if (!m[23]) return {s, 31'h0, 3'b000};
        return {s, ez, m[22:0], 3'b000};
    endfunction

    // Driver: present one operation at a negedge, wait for acceptance and for
    // out_valid (bounded). Leaves the bench at a negedge with out_valid seen.
    task automatic drive_op(input logic s, input logic [7:0] ez, input logic [23:0] m,
                            input logic uf, input logic ovc, input logic [4:0] n,
                            output logic [31:0] r, output logic [2:0] f, output int lat);
        int w;
        sign = s; Ez = ez; mant = m; underflow_flag = uf; overflow_case = ovc;
        mantissaReqiredModify = n;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            r = 32'hxxxxxxxx; f = 3'bxxx; lat = -1;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = result;
        f = {overflow, underflow, inexact};
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sign = 0; Ez = 0; mant = 0; underflow_flag = 0; overflow_case = 0;
        mantissaReqiredModify = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result);
        else pass_cnt++;
        chk_cnt++;
        if ({overflow, underflow, inexact} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {overflow, underflow, inexact});
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        chk_cnt++;
        if (dbg_state !== fp_pkg::ST_IDLE)
            $display("FAIL reset_state: got %0d want %0d", dbg_state, fp_pkg::ST_IDLE);
        else pass_cnt++;
    endtask

    typedef struct {
        logic s; logic [7:0] ez; logic [23:0] m; logic uf; logic ovc; logic [4:0] n;
        logic [31:0] r; logic [2:0] f; int lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[9];
        logic [31:0] r;
        logic [2:0] f;
        int lat;
        v[0] = '{1'b0, 8'h80, 24'hC00000, 1'b0, 1'b0, 5'd0,  32'h40400000, 3'b000, 1};
        v[1] = '{1'b1, 8'h10, 24'h800000, 1'b0, 1'b1, 5'd0,  32'hFF800000, 3'b101, 1};
        v[2] = '{1'b0, 8'h00, 24'h800001, 1'b1, 1'b0, 5'd1,  32'h00400000, 3'b011, 2};
        v[3] = '{1'b0, 8'h00, 24'hFFFFFF, 1'b1, 1'b0, 5'd1,
                 RNE ? 32'h00800000 : 32'h007FFFFF, 3'b011, 2};
        v[4] = '{1'b0, 8'h00, 24'h800000, 1'b1, 1'b0, 5'd24, 32'h00000000, 3'b011, 25};
        v[5] = '{1'b1, 8'h40, 24'h400000, 1'b0, 1'b0, 5'd0,  32'h80000000, 3'b000, 1};
        v[6] = '{1'b0, 8'hFF, 24'h900000, 1'b0, 1'b0, 5'd0,  32'h7F800000, 3'b101, 1};
        v[7] = '{1'b0, 8'h00, 24'hC00001, 1'b1, 1'b0, 5'd0,  32'h00C00001, 3'b010, 1};
        v[8] = '{1'b1, 8'h00, 24'hFFFFFF, 1'b1, 1'b0, 5'd31, 32'h80000000, 3'b011, 32};
        for (int i = 0; i < 9; i++) begin
            drive_op(v[i].s, v[i].ez, v[i].m, v[i].uf, v[i].ovc, v[i].n, r, f, lat);
            chk_cnt++;
            if (r !== v[i].r) $display("FAIL dir%0d_result: got %h want %h", i, r, v[i].r);
            else pass_cnt++;
            chk_cnt++;
            if (f !== v[i].f) $display("FAIL dir%0d_flags: got %b want %b", i, f, v[i].f);
            else pass_cnt++;
            chk_cnt++;
            if (lat !== v[i].lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat);
            else pass_cnt++;
            handshake();
        end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        logic [2:0] f;
        int lat;
        out_ready = 1'b0;
        drive_op(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 5'd0, r, f, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk_cnt++;
            if (result !== 32'h3F800000) $display("FAIL stall_result: got %h want 3f800000", result);
            else pass_cnt++;
            chk_cnt++;
            if (out_valid !== 1'b1) $display("FAIL stall_out_valid: got %b want 1", out_valid);
            else pass_cnt++;
            chk_cnt++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready);
            else pass_cnt++;
        end
        handshake();
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_release: got valid=%b ready=%b want valid=0 ready=1",
                     out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        sign = 1'b1; Ez = 8'h00; mant = 24'hABCDEF; underflow_flag = 1'b1;
        overflow_case = 1'b0; mantissaReqiredModify = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midshift_busy: got valid=%b ready=%b want 0 0", out_valid, in_ready);
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midshift_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (result !== 32'h0) $display("FAIL midshift_result: got %h want 00000000", result);
        else pass_cnt++;
        chk_cnt++;
        if ({overflow, underflow, inexact} !== 3'b000)
            $display("FAIL midshift_flags: got %b want 000", {overflow, underflow, inexact});
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midshift_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midshift_dropped: got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [2:0] f;
        int lat;
        logic [34:0] e;
        drive_op(1'b0, 8'h01, 24'hFFFFFF, 1'b0, 1'b0, 5'd0, r, f, lat);
        handshake();
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        e = model(1'b1, 8'h00, 24'h8000FF, 1'b1, 1'b0, 5'd8);
        drive_op(1'b1, 8'h00, 24'h8000FF, 1'b1, 1'b0, 5'd8, r, f, lat);
        chk_cnt++;
        if ({r, f} !== e) $display("FAIL b2b_second: got %h want %h", {r, f}, e);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== 9) $display("FAIL b2b_latency: got %0d want 9", lat);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [2:0] f;
        int lat, exp_lat;
        logic s, uf, ovc;
        logic [7:0] ez;
        logic [23:0] m;
        logic [4:0] n;
        logic [34:0] e;
        for (int i = 0; i < 60; i++) begin
            s   = 1'($urandom);
            ovc = ($urandom_range(0, 9) == 0);
            ez  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            uf  = 1'($urandom);
            n   = 5'($urandom);
            m   = {($urandom_range(0, 7) != 0), 23'($urandom)};
            exp_q.push_back(model(s, ez, m, uf, ovc, n));
            exp_lat = (uf && !(ovc || ez == 8'hFF)) ? 1 + int'(n) : 1;
            drive_op(s, ez, m, uf, ovc, n, r, f, lat);
            e = exp_q.pop_front();
            chk_cnt++;
            if ({r, f} !== e) $display("FAIL rand%0d_result: got %h want %h", i, {r, f}, e);
            else pass_cnt++;
            chk_cnt++;
            if (lat !== exp_lat) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_lat);
            else pass_cnt++;
            handshake();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fp_result_packer.md
# fp_result_packer

Back-end stage of the FP multiplier datapath. Consumes the exponent-update outputs (final exponent, underflow/overflow indications, underflow mantissa right-shift amount) and the normalized 24-bit product mantissa. Performs the subnormal right shift serially, one bit per cycle, with sticky tracking and optional round-to-nearest-even. Packs the IEEE-754 single-precision result with exception flags behind a valid/ready handshake.

## Interface
Parameters:
- `MANT_W`, 24: mantissa width including hidden bit.
- `SHIFT_W`, 5: width of the shift amount.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input operands valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `sign`  in  1  result sign.
- `Ez`  in  8  biased exponent from exponent update.
- `mant`  in  MANT_W  normalized mantissa; bit 23 is the hidden bit.
- `underflow_flag`  in  1  result is tiny; apply subnormal shift.
- `overflow_case`  in  1  exponent overflowed.
- `mantissaReqiredModify`  in  SHIFT_W  right-shift amount N for underflow (0..31).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `result`  out  32  packed float.
- `overflow`  out  1  overflow exception.
- `underflow`  out  1  underflow exception.
- `inexact`  out  1  nonzero bits discarded.

## Operation
- FSM states: IDLE, SHIFT, OUT.
- IDLE: accept on `in_valid && in_ready`. Latch all inputs.
  - If `overflow_case` is set, or `Ez`==8'hFF: result = {sign, 8'hFF, 23'h0}, overflow=1, inexact=1. Go to OUT.
  - Else if `underflow_flag` is set: load the counter with N and clear guard and sticky. Go to SHIFT; if N==0, go straight to OUT.
  - Else if `mant[23]`==0: result = {sign, 31'h0}, no flags. Go to OUT.
  - Else: result = {sign, Ez, mant[22:0]}, no flags. Go to OUT.
- SHIFT, each cycle:
  - sticky |= guard; guard = m[0]; m = m>>1; counter -= 1.
  - Leave SHIFT when the counter reaches 0.
  - N≥24 yields m==0, with guard and sticky reflecting the discarded bits.
- Subnormal pack: {exp, frac} = {8'h00, 23'h0} + m + rnd, so m[23] lands as an exponent field of 1.
  - A rounding carry from frac 0x7FFFFF gives 0x00800000, the minimum normal.
  - underflow=1, inexact = guard|sticky.
- OUT: hold `result` and the flags stable while `out_valid`=1. Return to IDLE on `out_ready`.
- Reset (any state, including mid-SHIFT): state=IDLE, `out_valid`=0, `result`=0, all flags 0, `in_ready`=1 from the cycle after reset deasserts. Any in-flight operation is dropped.

## Timing
- Normal, overflow, zero, or underflow with N=0: accept at edge T, `out_valid` at T+1.
- Underflow with N>0: `out_valid` at T+1+N. Worst case is N=31, giving 32 cycles.
- No overlap: `in_ready`=0 from acceptance until the OUT→IDLE transition. The earliest next accept is 1 cycle after the `out_ready` handshake.
- `out_ready` held low: outputs frozen indefinitely.

## Configuration
- `FP_PACK_RNE_EN` defined: rnd = guard & (sticky | m[0]), i.e. round-to-nearest-even, applied only in subnormal pack.
- Undefined: rnd=0 (truncate toward zero). Guard and sticky still drive `inexact`.

## Structure
- Shared package `fp_pkg`:
  - Field widths: EXP_W=8, FRAC_W=23.
  - EXP_MAX=8'hFF.
  - FSM state enum.
  - Flag struct {overflow, underflow, inexact}.
- One sub-module is natural: `fp_sticky_shifter`. It holds the serial shift register, counter, guard and sticky, with load/busy/done ports.
- Pack and round logic stays in the top.

## Test plan
- Normal: sign=0, Ez=8'h80, mant=24'hC00000 → result 32'h40400000, flags 0, `out_valid` 1 cycle after accept.
- Overflow: sign=1, overflow_case=1 → 32'hFF800000, overflow=1, inexact=1.
- Underflow N=1, mant=24'h800001:
  - Result 32'h00400000, underflow=1, inexact=1 (tie-to-even gives no round).
  - `out_valid` at accept+2.
- Underflow N=1, mant=24'hFFFFFF:
  - With RNE: 32'h00800000.
  - Without RNE: 32'h007FFFFF.
  - Both: inexact=1.
- Underflow N=24, mant=24'h800000: result 32'h00000000, underflow=1, inexact=1. Latency is 25 cycles.
- Handshake and reset:
  - Hold `out_ready`=0 for 5 cycles → result stable, `in_ready`=0.
  - Assert `rst` mid-SHIFT (N=20) → next cycle IDLE, `out_valid`=0, outputs 0.
